alu: RTL and testbench
======================

# alu

Integer execution unit with an embedded 8-entry reservation station for the out-of-order core. It accepts dispatched ALU micro-ops, captures operand values and ROB-tag dependencies, and wakes waiting operands from the ROB/CDB broadcast. Each cycle it issues at most one ready entry and writes the result back toward the ROB.

## Interface
- `WIDTH`, 32: datapath width (`COMMON_WIDTH` = `[WIDTH-1:0]`).
- `ENTRIES`, 8: reservation-station depth.
- `TAG_W`, 4: ROB tag width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `new_entry`  `alu_reserv_inf`  —  dispatch port; see fields below.
  - `valid` (in): dispatch request.
  - `op[3:0]` (in): ALU opcode.
  - `val1`, `val2` [WIDTH] (in): operand values.
  - `rdy1`, `rdy2` (in): operand value is present.
  - `q1`, `q2` [TAG_W] (in): producer ROB tag for an operand that is not ready.
  - `dest` [TAG_W] (in): destination ROB tag.
  - `full` (out): no free entry.
- `rob_info`  `rob_inf`  —  ROB port; see fields below.
  - `cdb_valid`, `cdb_tag`, `cdb_value` (in): result broadcast.
  - `flush` (in): squash all entries.
  - `wb_valid`, `wb_tag` (out): writeback to the ROB.
- `result`  out  WIDTH  value written back; qualified by `rob_info.wb_valid`.

## Operation
- Storage is the array `entries[0:ENTRIES-1]` with fields:
  - `valid`, `op`, `dest`
  - `val[1]`, `val[2]`
  - `rdy[1]`, `rdy[2]`
  - `q[1]`, `q[2]`
- Verification may force these fields hierarchically. A forced entry with `valid=1` and both `rdy=1` must issue normally.
- Provide a debug task `test_add` that fills all entries:
  - `valid=1`, `op=ALU_ADD`
  - `val[1]=1`, `val[2]=2`, both operands ready
  - `dest=i`
- Allocation:
  - Condition: `new_entry.valid && !full`.
  - Writes the lowest-index invalid entry.
  - Requests made while `full` are ignored; the dispatcher must hold them.
- `full` = all entries valid. It is combinational from the current state and does not anticipate this cycle's issue.
- Wakeup:
  - On `cdb_valid`, every valid entry with `rdy[k]=0 && q[k]==cdb_tag` takes `val[k]=cdb_value` and sets `rdy[k]=1`.
  - A dispatching operand whose `q` matches a same-cycle broadcast is captured as ready (bypass).
- Issue:
  - Select the lowest-index entry with `valid && rdy[1] && rdy[2]`.
  - Compute combinationally.
  - At the edge: clear that entry, register `result`, set `wb_valid=1` and `wb_tag=dest`.
  - If nothing is ready, `wb_valid=0` and `result` holds its value.
- Opcodes (`a=val[1]`, `b=val[2]`), results modulo 2^WIDTH:
  - `ALU_ADD=0`: a+b
  - `SUB=1`: a-b
  - `AND=2`, `OR=3`, `XOR=4`: bitwise
  - `SLL=5`: a << b[4:0]
  - `SRL=6`: logical a >> b[4:0]
  - `SRA=7`: arithmetic a >> b[4:0]
  - `SLT=8`: signed a<b → 1, else 0
  - `SLTU=9`: unsigned a<b → 1, else 0
  - Codes 10–15 produce 0.
- Flush: clears all `valid` bits and forces `wb_valid=0` at the edge. It overrides a same-cycle allocation and issue.

## Timing
- Reset values:
  - all `entries[i].valid=0`
  - `result=0`, `wb_valid=0`, `wb_tag=0`
  - `full=0` after reset
- Reset mid-operation discards all pending entries; nothing issues in the reset cycle.
- Dispatch-to-issue latency:
  - An entry written at edge N is eligible at N+1.
  - Its `result`/`wb_valid` appear after edge N+1, giving one-cycle minimum occupancy.
- Wakeup at edge N makes the entry eligible at N+1.
- Throughput is one issue per cycle. Issue order is by index, not age.
- An entry freed by issue at edge N is allocatable in the cycle after N; `full` deasserts then.
- Simultaneous allocate and issue in one cycle are both performed.

## Test plan
- Backdoor fill via `test_add`, no dispatch: `result=3` with `wb_valid=1` for 8 consecutive cycles, `wb_tag` 0..7 in order. Then `wb_valid=0` and `full=0`.
- Dispatch `SUB` 5-7, both ready, `dest=2`: next cycle `result=0xFFFFFFFE`, `wb_tag=2`. Also `SRA 0x80000000,4` gives `0xF8000000`, and `SLT -1,1` gives 1.
- Dispatch `ADD` with `rdy1=0`, `q1=5`, `val2=10`: no writeback. Then `cdb_valid`, `cdb_tag=5`, `cdb_value=32` gives `result=42` one cycle later. A same-cycle dispatch plus broadcast also gives 42.
- Dispatch 8 blocked entries: `full=1`. A 9th request is ignored; the entry count stays 8.
- Assert `rst` (or `flush`) with 4 pending entries: next cycle all invalid, `wb_valid=0`, `result=0` (reset only), and no later writebacks.

Source files
------------

// File: rtl/alu_if.sv
// Dispatch and ROB/CDB interface bundles for the ALU reservation station.
interface alu_reserv_inf #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             valid;
  logic [3:0]       op;
  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val2;
  logic             rdy1;
  logic             rdy2;
  logic [TAG_W-1:0] q1;
  logic [TAG_W-1:0] q2;
  logic [TAG_W-1:0] dest;
  logic             full;

  modport alu  (input valid, op, val1, val2, rdy1, rdy2, q1, q2, dest, output full);
  modport disp (output valid, op, val1, val2, rdy1, rdy2, q1, q2, dest, input full);
endinterface

interface rob_inf #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [WIDTH-1:0] cdb_value;
  logic             flush;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;

  modport alu (input cdb_valid, cdb_tag, cdb_value, flush, output wb_valid, wb_tag);
  modport rob (output cdb_valid, cdb_tag, cdb_value, flush, input wb_valid, wb_tag);
endinterface

// File: rtl/alu.sv
// Integer execution unit with an embedded reservation station: allocates
// dispatched micro-ops, wakes operands from the CDB and issues one per cycle.
module alu #(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 8,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_reserv_inf.alu       new_entry,
  rob_inf.alu              rob_info,
  output logic [WIDTH-1:0] result
);
  localparam int IDX_W = $clog2(ENTRIES);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef struct packed {
    logic                        valid;
    logic [3:0]                  op;
    logic [TAG_W-1:0]            dest;
    logic [1:2][WIDTH-1:0]       val;
    logic [1:2]                  rdy;
    logic [1:2][TAG_W-1:0]       q;
  } entry_t;

  entry_t entries [0:ENTRIES-1];

  logic [ENTRIES-1:0] valid_vec;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   free_idx;
  logic               alloc;
  logic [WIDTH-1:0]   a, b, alu_out;
  logic [4:0]         shamt;
  logic               byp1, byp2;

  // Lowest index wins for both issue select and allocation.
  always_comb begin
    valid_vec = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      valid_vec[i] = entries[i].valid;
      if (entries[i].valid && (&entries[i].rdy)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!entries[i].valid) free_idx = IDX_W'(i);
    end
  end

  assign new_entry.full = &valid_vec;
  assign alloc = new_entry.valid && !new_entry.full;
  assign byp1  = rob_info.cdb_valid && !new_entry.rdy1 && (new_entry.q1 == rob_info.cdb_tag);
  assign byp2  = rob_info.cdb_valid && !new_entry.rdy2 && (new_entry.q2 == rob_info.cdb_tag);

  assign a     = entries[sel_idx].val[1];
  assign b     = entries[sel_idx].val[2];
  assign shamt = b[4:0];

  always_comb begin
    alu_out = '0;
    case (entries[sel_idx].op)
      ALU_ADD:  alu_out = a + b;
      ALU_SUB:  alu_out = a - b;
      ALU_AND:  alu_out = a & b;
      ALU_OR:   alu_out = a | b;
      ALU_XOR:  alu_out = a ^ b;
      ALU_SLL:  alu_out = a << shamt;
      ALU_SRL:  alu_out = a >> shamt;
      ALU_SRA:  alu_out = $signed(a) >>> shamt;
      ALU_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (a < b)};
      default:  alu_out = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) entries[i].valid <= 1'b0;
      result            <= '0;
      rob_info.wb_valid <= 1'b0;
      rob_info.wb_tag   <= '0;
    end else if (rob_info.flush) begin
      for (int i = 0; i < ENTRIES; i++) entries[i].valid <= 1'b0;
      rob_info.wb_valid <= 1'b0;
    end else begin
      if (rob_info.cdb_valid) begin
        for (int i = 0; i < ENTRIES; i++) begin
          for (int k = 1; k <= 2; k++) begin
            if (entries[i].valid && !entries[i].rdy[k] && (entries[i].q[k] == rob_info.cdb_tag)) begin
              entries[i].val[k] <= rob_info.cdb_value;
              entries[i].rdy[k] <= 1'b1;
            end
          end
        end
      end
      if (sel_found) begin
        entries[sel_idx].valid <= 1'b0;
        result                 <= alu_out;
        rob_info.wb_tag        <= entries[sel_idx].dest;
      end
      rob_info.wb_valid <= sel_found;
      // The free slot is never the issuing slot, so both updates coexist.
      if (alloc) begin
        entries[free_idx].valid  <= 1'b1;
        entries[free_idx].op     <= new_entry.op;
        entries[free_idx].dest   <= new_entry.dest;
        entries[free_idx].val[1] <= byp1 ? rob_info.cdb_value : new_entry.val1;
        entries[free_idx].val[2] <= byp2 ? rob_info.cdb_value : new_entry.val2;
        entries[free_idx].rdy[1] <= new_entry.rdy1 | byp1;
        entries[free_idx].rdy[2] <= new_entry.rdy2 | byp2;
        entries[free_idx].q[1]   <= new_entry.q1;
        entries[free_idx].q[2]   <= new_entry.q2;
      end
    end
  end
endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the alu reservation station.
module tb_alu;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] result;
  int          checks = 0;
  int          passed = 0;

  alu_reserv_inf #(.WIDTH(32), .TAG_W(4)) ne ();
  rob_inf        #(.WIDTH(32), .TAG_W(4)) rb ();

  alu #(.WIDTH(32), .ENTRIES(8), .TAG_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .new_entry(ne),
    .rob_info (rb),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int count_valid();
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(dut.entries[i].valid);
    return c;
  endfunction

  // Backdoor fill: every entry holds a ready ADD 1+2 with dest = index.
  task automatic test_add();
    for (int i = 0; i < 8; i++) begin
      dut.entries[i].valid  <= 1'b1;
      dut.entries[i].op     <= 4'd0;
      dut.entries[i].val[1] <= 32'd1;
      dut.entries[i].val[2] <= 32'd2;
      dut.entries[i].rdy    <= 2'b11;
      dut.entries[i].q      <= '0;
      dut.entries[i].dest   <= 4'(i);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] v1, input logic [31:0] v2,
                       input logic r1, input logic r2, input logic [3:0] q1,
                       input logic [3:0] q2, input logic [3:0] dest);
    ne.valid = 1'b1; ne.op = op; ne.val1 = v1; ne.val2 = v2;
    ne.rdy1 = r1; ne.rdy2 = r2; ne.q1 = q1; ne.q2 = q2; ne.dest = dest;
  endtask

  task automatic dispatch(input logic [3:0] op, input logic [31:0] v1, input logic [31:0] v2,
                          input logic r1, input logic r2, input logic [3:0] q1,
                          input logic [3:0] q2, input logic [3:0] dest);
    drive(op, v1, v2, r1, r2, q1, q2, dest);
    step();
    ne.valid = 1'b0;
  endtask

  task automatic broadcast(input logic [3:0] tag, input logic [31:0] value);
    rb.cdb_valid = 1'b1; rb.cdb_tag = tag; rb.cdb_value = value;
    step();
    rb.cdb_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (rb.wb_valid !== 1'b0) $display("FAIL reset_wb_valid got %b want 0", rb.wb_valid); else passed++;
    checks++; if (result !== 32'd0) $display("FAIL reset_result got %h want 0", result); else passed++;
    checks++; if (rb.wb_tag !== 4'd0) $display("FAIL reset_wb_tag got %0d want 0", rb.wb_tag); else passed++;
    checks++; if (ne.full !== 1'b0) $display("FAIL reset_full got %b want 0", ne.full); else passed++;
    checks++; if (count_valid() !== 0) $display("FAIL reset_count got %0d want 0", count_valid()); else passed++;
  endtask

  task automatic test_backdoor();
    test_add();
    #1;
    checks++; if (ne.full !== 1'b1) $display("FAIL backdoor_full got %b want 1", ne.full); else passed++;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (rb.wb_valid !== 1'b1 || result !== 32'd3 || rb.wb_tag !== 4'(i))
        $display("FAIL backdoor_issue%0d got v=%b r=%h t=%0d want v=1 r=3 t=%0d", i, rb.wb_valid, result, rb.wb_tag, i);
      else passed++;
    end
    step();
    checks++; if (rb.wb_valid !== 1'b0) $display("FAIL backdoor_drain_wb got %b want 0", rb.wb_valid); else passed++;
    checks++; if (ne.full !== 1'b0) $display("FAIL backdoor_drain_full got %b want 0", ne.full); else passed++;
  endtask

  task automatic test_ops();
    logic [3:0]  ops [7] = '{4'd1, 4'd7, 4'd8, 4'd9, 4'd5, 4'd4, 4'd12};
    logic [31:0] va  [7] = '{32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'hF0F0_1234, 32'd77};
    logic [31:0] vb  [7] = '{32'd7, 32'd4, 32'd1, 32'd1, 32'd33, 32'h0FF0_1234, 32'd3};
    logic [31:0] exp [7] = '{32'hFFFF_FFFE, 32'hF800_0000, 32'd1, 32'd0, 32'd2, 32'hFF00_0000, 32'd0};
    logic [3:0]  dst [7] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14};
    for (int i = 0; i < 7; i++) begin
      dispatch(ops[i], va[i], vb[i], 1'b1, 1'b1, 4'd0, 4'd0, dst[i]);
      checks++; if (rb.wb_valid !== 1'b0) $display("FAIL op%0d_occupancy got wb_valid=%b want 0", i, rb.wb_valid); else passed++;
      step();
      checks++;
      if (rb.wb_valid !== 1'b1 || result !== exp[i] || rb.wb_tag !== dst[i])
        $display("FAIL op%0d got v=%b r=%h t=%0d want v=1 r=%h t=%0d", i, rb.wb_valid, result, rb.wb_tag, exp[i], dst[i]);
      else passed++;
    end
    step();
  endtask

  task automatic test_wakeup();
    dispatch(4'd0, 32'd0, 32'd10, 1'b0, 1'b1, 4'd5, 4'd0, 4'd3);
    step();
    checks++; if (rb.wb_valid !== 1'b0) $display("FAIL wake_blocked got wb_valid=%b want 0", rb.wb_valid); else passed++;
    broadcast(4'd5, 32'd32);
    checks++; if (rb.wb_valid !== 1'b0) $display("FAIL wake_latency got wb_valid=%b want 0", rb.wb_valid); else passed++;
    step();
    checks++;
    if (rb.wb_valid !== 1'b1 || result !== 32'd42 || rb.wb_tag !== 4'd3)
      $display("FAIL wake_result got v=%b r=%0d t=%0d want v=1 r=42 t=3", rb.wb_valid, result, rb.wb_tag);
    else passed++;
    step();
    drive(4'd0, 32'd0, 32'd10, 1'b0, 1'b1, 4'd6, 4'd0, 4'd11);
    broadcast(4'd6, 32'd32);
    ne.valid = 1'b0;
    step();
    checks++;
    if (rb.wb_valid !== 1'b1 || result !== 32'd42 || rb.wb_tag !== 4'd11)
      $display("FAIL bypass_result got v=%b r=%0d t=%0d want v=1 r=42 t=11", rb.wb_valid, result, rb.wb_tag);
    else passed++;
    step();
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) dispatch(4'd0, 32'd0, 32'(i), 1'b0, 1'b1, 4'd15, 4'd0, 4'(i));
    checks++; if (ne.full !== 1'b1) $display("FAIL full_set got %b want 1", ne.full); else passed++;
    dispatch(4'd0, 32'd1, 32'd1, 1'b1, 1'b1, 4'd0, 4'd0, 4'd9);
    checks++; if (count_valid() !== 8) $display("FAIL full_ignore_count got %0d want 8", count_valid()); else passed++;
    checks++; if (rb.wb_valid !== 1'b0) $display("FAIL full_ignore_wb got %b want 0", rb.wb_valid); else passed++;
    broadcast(4'd15, 32'd100);
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (rb.wb_valid !== 1'b1 || result !== 32'(100 + i) || rb.wb_tag !== 4'(i))
        $display("FAIL full_drain%0d got v=%b r=%0d t=%0d want v=1 r=%0d t=%0d", i, rb.wb_valid, result, rb.wb_tag, 100 + i, i);
      else passed++;
      if (i == 0) begin
        checks++; if (ne.full !== 1'b0) $display("FAIL full_release got %b want 0", ne.full); else passed++;
      end
    end
    step();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) dispatch(4'd0, 32'd0, 32'd1, 1'b0, 1'b1, 4'd7, 4'd0, 4'(i));
    drive(4'd0, 32'd5, 32'd5, 1'b1, 1'b1, 4'd0, 4'd0, 4'd13);
    rb.flush = 1'b1;
    step();
    rb.flush = 1'b0;
    ne.valid = 1'b0;
    checks++; if (count_valid() !== 0) $display("FAIL flush_count got %0d want 0", count_valid()); else passed++;
    checks++; if (rb.wb_valid !== 1'b0) $display("FAIL flush_wb got %b want 0", rb.wb_valid); else passed++;
    checks++; if (ne.full !== 1'b0) $display("FAIL flush_full got %b want 0", ne.full); else passed++;
    broadcast(4'd7, 32'd9);
    step();
    checks++; if (rb.wb_valid !== 1'b0) $display("FAIL flush_no_later_wb got %b want 0", rb.wb_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) dispatch(4'd0, 32'd0, 32'd1, 1'b0, 1'b1, 4'd8, 4'd0, 4'(i));
    dispatch(4'd0, 32'd20, 32'd22, 1'b1, 1'b1, 4'd0, 4'd0, 4'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (count_valid() !== 0) $display("FAIL rstmid_count got %0d want 0", count_valid()); else passed++;
    checks++; if (rb.wb_valid !== 1'b0) $display("FAIL rstmid_wb got %b want 0", rb.wb_valid); else passed++;
    checks++; if (result !== 32'd0) $display("FAIL rstmid_result got %h want 0", result); else passed++;
    broadcast(4'd8, 32'd9);
    step();
    checks++; if (rb.wb_valid !== 1'b0) $display("FAIL rstmid_no_later_wb got %b want 0", rb.wb_valid); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    ne.valid = 1'b0; ne.op = '0; ne.val1 = '0; ne.val2 = '0;
    ne.rdy1 = 1'b0; ne.rdy2 = 1'b0; ne.q1 = '0; ne.q2 = '0; ne.dest = '0;
    rb.cdb_valid = 1'b0; rb.cdb_tag = '0; rb.cdb_value = '0; rb.flush = 1'b0;
    @(negedge clk);
    test_reset();
    test_backdoor();
    test_ops();
    test_wakeup();
    test_full();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
